// File: rtl/func_pkg.sv
// Shared definitions for the function sequencer: func codes, entry layout, FSM states.
// Entry byte layout: [7] last, [6:4] func, [3:0] memory address.
package func_pkg;

    localparam int DEPTH   = 16;
    localparam int PC_W    = 4;
    localparam int ENTRY_W = 8;
    localparam int FUNC_W  = 3;
    localparam int ADDR_W  = 4;

    localparam int LAST_BIT = 7;
    localparam int FUNC_MSB = 6;
    localparam int FUNC_LSB = 4;
    localparam int ADDR_MSB = 3;
    localparam int ADDR_LSB = 0;

    localparam logic [FUNC_W-1:0] FUNC_ROM_OUT    = 3'd0;
    localparam logic [FUNC_W-1:0] FUNC_RAM_OUT    = 3'd1;
    localparam logic [FUNC_W-1:0] FUNC_SW_OUT     = 3'd2;
    localparam logic [FUNC_W-1:0] FUNC_SW_TO_RAM  = 3'd3;
    localparam logic [FUNC_W-1:0] FUNC_ROM_TO_RAM = 3'd4;
    localparam logic [FUNC_W-1:0] FUNC_SW_TO_LED  = 3'd5;
    localparam logic [FUNC_W-1:0] FUNC_ROM_TO_LED = 3'd6;
    localparam logic [FUNC_W-1:0] FUNC_RAM_TO_LED = 3'd7;

    // Bit n set means func code n occupies the bus for two cycles.
    localparam logic [7:0] TWO_CYCLE_SET = 8'b1111_1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_WAIT_STEP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic              last;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    function automatic entry_t decode_entry(input logic [ENTRY_W-1:0] raw);
        entry_t e;
        e.last = raw[LAST_BIT];
        e.func = raw[FUNC_MSB:FUNC_LSB];
        e.addr = raw[ADDR_MSB:ADDR_LSB];
        return e;
    endfunction

    function automatic logic is_two_cycle(input logic [FUNC_W-1:0] f);
        return TWO_CYCLE_SET[f];
    endfunction

endpackage

// File: rtl/func_sequencer_if.sv
// Program-load, run-control and function-issue signals of the sequencer.
// master = controller/host side, slave = the sequencer itself.
interface func_sequencer_if;
    import func_pkg::*;

    logic                prog_we;
    logic [PC_W-1:0]     prog_addr;
    logic [ENTRY_W-1:0]  prog_data;
    logic                start;
    logic                step_mode;
    logic                step;
    logic                abort;
    logic [FUNC_W-1:0]   func;
    logic [ADDR_W-1:0]   addr;
    logic [PC_W-1:0]     pc;
    logic                busy;
    logic                done;

    modport master (
        output prog_we, prog_addr, prog_data, start, step_mode, step, abort,
        input  func, addr, pc, busy, done
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, step_mode, step, abort,
        output func, addr, pc, busy, done
    );

endinterface

// File: rtl/prog_mem.sv
// 16 x 8 program store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a program survives a sequencer reset.
module prog_mem
    import func_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [PC_W-1:0]    waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/func_sequencer.sv
// Steps through a stored program, issuing func/addr for one or two cycles per entry.
// Supports single-step, abort at entry boundaries, and a one-cycle done pulse.
module func_sequencer
    import func_pkg::*;
(
    input  logic          clk,
    input  logic          n_reset,
    func_sequencer_if.slave sif
);

    state_t             state;
    state_t             state_nxt;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_nxt;
    logic [ENTRY_W-1:0] raw_entry;
    entry_t             ent;
    logic               mem_we;

    state_t             bnd_state;
    logic [PC_W-1:0]    bnd_pc;

    logic [FUNC_W-1:0]  func_o;
    logic [ADDR_W-1:0]  addr_o;
    logic               busy_o;
    logic               done_o;

    // Program may only change while no run is in progress.
    assign mem_we = sif.prog_we && (state == S_IDLE);

    prog_mem u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (sif.prog_addr),
        .wdata (sif.prog_data),
        .raddr (pc),
        .rdata (raw_entry)
    );

    assign ent = decode_entry(raw_entry);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Decision taken on the last cycle of an entry; pc 15 always terminates.
    always_comb begin
        bnd_state = S_ISSUE;
        bnd_pc    = pc + 4'd1;
        if (sif.abort) begin
            bnd_state = S_IDLE;
            bnd_pc    = pc;
        end else if (ent.last || (pc == 4'd15)) begin
            bnd_state = S_DONE;
            bnd_pc    = pc;
        end else if (sif.step_mode) begin
            bnd_state = S_WAIT_STEP;
            bnd_pc    = pc;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_IDLE: begin
                if (sif.start) begin
                    state_nxt = S_ISSUE;
                    pc_nxt    = '0;
                end
            end
            S_ISSUE: begin
                if (is_two_cycle(ent.func)) begin
                    state_nxt = S_HOLD;
                end else begin
                    state_nxt = bnd_state;
                    pc_nxt    = bnd_pc;
                end
            end
            S_HOLD: begin
                state_nxt = bnd_state;
                pc_nxt    = bnd_pc;
            end
            S_WAIT_STEP: begin
                if (sif.abort) begin
                    state_nxt = S_IDLE;
                end else if (sif.step) begin
                    state_nxt = S_ISSUE;
                    pc_nxt    = pc + 4'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        func_o = FUNC_ROM_OUT;
        addr_o = '0;
        busy_o = (state != S_IDLE);
        done_o = (state == S_DONE);
        if ((state == S_ISSUE) || (state == S_HOLD)) begin
            func_o = ent.func;
            addr_o = ent.addr;
        end
    end

    assign sif.func = func_o;
    assign sif.addr = addr_o;
    assign sif.pc   = pc;
    assign sif.busy = busy_o;
    assign sif.done = done_o;

endmodule

// File: tb/tb_func_sequencer.sv
// Directed bench for func_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_func_sequencer;

    logic clk = 1'b0;
    logic n_reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    func_sequencer_if sif ();

    func_sequencer dut (
        .clk     (clk),
        .n_reset (n_reset),
        .sif     (sif.slave)
    );

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        sif.prog_we   = 1'b1;
        sif.prog_addr = a;
        sif.prog_data = d;
        @(negedge clk);
        sif.prog_we   = 1'b0;
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.func !== 3'd0 ||
            sif.addr !== 4'd0 || sif.pc !== 4'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b func=%0d addr=%0h pc=%0d, required all zero",
                     sif.busy, sif.done, sif.func, sif.addr, sif.pc);
        end
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    // Entries 0x12, 0x35, 0x8A: 1/2 for one cycle, 3/5 for two, 0/A for one, then done.
    task automatic test_run;
        logic [2:0] ef [6];
        logic [3:0] ea [6];
        logic [3:0] ep [6];
        logic       eb [6];
        logic       ed [6];
        ef = '{3'd1, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0};
        ea = '{4'h2, 4'h5, 4'h5, 4'hA, 4'h0, 4'h0};
        ep = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2};
        eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        load(4'd0, 8'h12);
        load(4'd1, 8'h35);
        load(4'd2, 8'h8A);
        sif.step_mode = 1'b0;
        sif.start     = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (sif.func !== ef[i] || sif.addr !== ea[i] || sif.pc !== ep[i] ||
                sif.busy !== eb[i] || sif.done !== ed[i]) begin
                errors++;
                $display("FAIL run cyc%0d: func=%0d addr=%0h pc=%0d busy=%b done=%b, required %0d %0h %0d %b %b",
                         i, sif.func, sif.addr, sif.pc, sif.busy, sif.done,
                         ef[i], ea[i], ep[i], eb[i], ed[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_step;
        sif.step_mode = 1'b1;
        sif.start     = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        checks++;
        if (sif.func !== 3'd1 || sif.addr !== 4'h2 || sif.pc !== 4'd0) begin
            errors++;
            $display("FAIL step e0: func=%0d addr=%0h pc=%0d, required 1 2 0", sif.func, sif.addr, sif.pc);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (sif.func !== 3'd0 || sif.addr !== 4'd0 || sif.pc !== 4'd0 || sif.busy !== 1'b1) begin
                errors++;
                $display("FAIL step wait0 k%0d: func=%0d addr=%0h pc=%0d busy=%b, required 0 0 0 1",
                         k, sif.func, sif.addr, sif.pc, sif.busy);
            end
        end
        sif.step = 1'b1;
        @(negedge clk);
        sif.step = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (sif.func !== 3'd3 || sif.addr !== 4'h5 || sif.pc !== 4'd1) begin
                errors++;
                $display("FAIL step e1 k%0d: func=%0d addr=%0h pc=%0d, required 3 5 1",
                         k, sif.func, sif.addr, sif.pc);
            end
            @(negedge clk);
        end
        checks++;
        if (sif.func !== 3'd0 || sif.pc !== 4'd1 || sif.busy !== 1'b1) begin
            errors++;
            $display("FAIL step wait1: func=%0d pc=%0d busy=%b, required 0 1 1", sif.func, sif.pc, sif.busy);
        end
        sif.step = 1'b1;
        @(negedge clk);
        sif.step = 1'b0;
        checks++;
        if (sif.func !== 3'd0 || sif.addr !== 4'hA || sif.pc !== 4'd2) begin
            errors++;
            $display("FAIL step e2: func=%0d addr=%0h pc=%0d, required 0 A 2", sif.func, sif.addr, sif.pc);
        end
        @(negedge clk);
        checks++;
        if (sif.done !== 1'b1 || sif.pc !== 4'd2) begin
            errors++;
            $display("FAIL step done: done=%b pc=%0d, required 1 2", sif.done, sif.pc);
        end
        @(negedge clk);
        sif.step_mode = 1'b0;
    endtask

    // Abort raised in ISSUE of a 4/7 entry and held: HOLD happens, then IDLE without done.
    task automatic test_abort;
        load(4'd0, 8'h47);
        load(4'd1, 8'h8A);
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        sif.abort = 1'b1;
        checks++;
        if (sif.func !== 3'd4 || sif.addr !== 4'h7) begin
            errors++;
            $display("FAIL abort issue: func=%0d addr=%0h, required 4 7", sif.func, sif.addr);
        end
        @(negedge clk);
        checks++;
        if (sif.func !== 3'd4 || sif.addr !== 4'h7 || sif.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort hold: func=%0d addr=%0h busy=%b, required 4 7 1", sif.func, sif.addr, sif.busy);
        end
        @(negedge clk);
        sif.abort = 1'b0;
        checks++;
        if (sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.func !== 3'd0 || sif.pc !== 4'd0) begin
            errors++;
            $display("FAIL abort idle: busy=%b done=%b func=%0d pc=%0d, required 0 0 0 0",
                     sif.busy, sif.done, sif.func, sif.pc);
        end
        @(negedge clk);
    endtask

    // Entry i = {last 0, func i%8, addr i}; start held and a write to entry 9 attempted mid-run.
    task automatic test_full;
        logic [2:0] f;
        int         n;
        for (int i = 0; i < 16; i++) begin
            f = 3'(i);
            load(4'(i), {1'b0, f, 4'(i)});
        end
        sif.start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            f = 3'(i);
            n = (i % 8 >= 3) ? 2 : 1;
            for (int k = 0; k < n; k++) begin
                checks++;
                if (sif.pc !== 4'(i) || sif.func !== f || sif.addr !== 4'(i) ||
                    sif.busy !== 1'b1 || sif.done !== 1'b0) begin
                    errors++;
                    $display("FAIL full e%0d k%0d: pc=%0d func=%0d addr=%0h busy=%b done=%b, required %0d %0d %0h 1 0",
                             i, k, sif.pc, sif.func, sif.addr, sif.busy, sif.done, i, f, i);
                end
                sif.start     = (i < 14);
                sif.prog_we   = (i < 8);
                sif.prog_addr = 4'd9;
                sif.prog_data = 8'h80;
                @(negedge clk);
            end
        end
        sif.prog_we = 1'b0;
        checks++;
        if (sif.done !== 1'b1 || sif.pc !== 4'd15) begin
            errors++;
            $display("FAIL full done: done=%b pc=%0d, required 1 15", sif.done, sif.pc);
        end
        @(negedge clk);
        checks++;
        if (sif.busy !== 1'b0 || sif.pc !== 4'd15 || sif.done !== 1'b0) begin
            errors++;
            $display("FAIL full idle: busy=%b pc=%0d done=%b, required 0 15 0", sif.busy, sif.pc, sif.done);
        end
    endtask

    // Reset during HOLD of entry 3 (func 3, addr 3), then rerun the same program.
    task automatic test_reset_hold;
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (sif.func !== 3'd3 || sif.addr !== 4'd3 || sif.pc !== 4'd3) begin
            errors++;
            $display("FAIL rst_hold pre: func=%0d addr=%0h pc=%0d, required 3 3 3", sif.func, sif.addr, sif.pc);
        end
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        checks++;
        if (sif.busy !== 1'b0 || sif.func !== 3'd0 || sif.addr !== 4'd0 ||
            sif.pc !== 4'd0 || sif.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold post: busy=%b func=%0d addr=%0h pc=%0d done=%b, required all zero",
                     sif.busy, sif.func, sif.addr, sif.pc, sif.done);
        end
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sif.pc !== 4'(i) || sif.func !== 3'(i) || sif.addr !== 4'(i)) begin
                errors++;
                $display("FAIL rerun e%0d: pc=%0d func=%0d addr=%0h, required %0d %0d %0h",
                         i, sif.pc, sif.func, sif.addr, i, i, i);
            end
            if (i == 3) sif.abort = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        sif.abort = 1'b0;
        checks++;
        if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
            errors++;
            $display("FAIL rerun abort: busy=%b done=%b, required 0 0", sif.busy, sif.done);
        end
    endtask

    initial begin
        n_reset       = 1'b0;
        sif.prog_we   = 1'b0;
        sif.prog_addr = '0;
        sif.prog_data = '0;
        sif.start     = 1'b0;
        sif.step_mode = 1'b0;
        sif.step      = 1'b0;
        sif.abort     = 1'b0;
        @(negedge clk);
        test_reset;
        test_run;
        test_step;
        test_abort;
        test_full;
        test_reset_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
